// File: rtl/alu_pkg.sv
// Shared types for the turtle-cpu ALU: function-select encoding.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOT = 3'b101,
        ALU_SHL = 3'b110,
        ALU_SHR = 3'b111
    } alu_func_e;

endpackage

// File: rtl/alu_addsub.sv
// Combinational W-bit adder/subtractor producing sum, carry-out and signed overflow.
// Subtraction is a + ~b + 1, so carry=1 means "no borrow".
module alu_addsub
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_sub,
    output logic [DATA_WIDTH-1:0] o_sum,
    output logic                  o_carry,
    output logic                  o_overflow
);

    logic [DATA_WIDTH-1:0] w_b;
    logic [DATA_WIDTH:0]   w_full;

    assign w_b    = i_sub ? ~i_b : i_b;
    assign w_full = {1'b0, i_a} + {1'b0, w_b} + {{DATA_WIDTH{1'b0}}, i_sub};

    assign o_sum   = w_full[DATA_WIDTH-1:0];
    assign o_carry = w_full[DATA_WIDTH];
    // Overflow on the effective operands covers both ADD and SUB with one rule.
    assign o_overflow = (i_a[DATA_WIDTH-1] == w_b[DATA_WIDTH-1]) &&
                        (o_sum[DATA_WIDTH-1] != i_a[DATA_WIDTH-1]);

endmodule

// File: rtl/alu_core.sv
// Registered integer ALU (latency 1) with carry and signed-overflow flags.
// Define ALU_ZERO_FLAG_EN to add the registered zero_flag output.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic [2:0]            func,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  signed_overflow,
    output logic                  carry_flag
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic                  zero_flag
`endif
);

    localparam int SHW = $clog2(DATA_WIDTH);

    alu_func_e             w_func;
    logic                  w_sub;
    logic [DATA_WIDTH-1:0] w_sum;
    logic                  w_as_carry;
    logic                  w_as_ovf;
    logic [SHW-1:0]        w_shamt;
    logic [DATA_WIDTH:0]   w_shl;
    logic [DATA_WIDTH:0]   w_shr;
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_c;
    logic                  w_v;

    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_ovf;
    logic                  r_carry;

    assign w_func = alu_func_e'(func);
    assign w_sub  = (w_func == ALU_SUB);

    alu_addsub #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_addsub (
        .i_a        (op_a),
        .i_b        (op_b),
        .i_sub      (w_sub),
        .o_sum      (w_sum),
        .o_carry    (w_as_carry),
        .o_overflow (w_as_ovf)
    );

    // One extra bit on each shifter catches the last bit shifted out (0 when n=0).
    assign w_shamt = op_b[SHW-1:0];
    assign w_shl   = {1'b0, op_a} << w_shamt;
    assign w_shr   = {op_a, 1'b0} >> w_shamt;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (w_func)
            ALU_ADD, ALU_SUB: begin
                w_res = w_sum;
                w_c   = w_as_carry;
                w_v   = w_as_ovf;
            end
            ALU_AND: w_res = op_a & op_b;
            ALU_OR:  w_res = op_a | op_b;
            ALU_XOR: w_res = op_a ^ op_b;
            ALU_NOT: w_res = ~op_a;
            ALU_SHL: begin
                w_res = w_shl[DATA_WIDTH-1:0];
                w_c   = w_shl[DATA_WIDTH];
            end
            ALU_SHR: begin
                w_res = w_shr[DATA_WIDTH:1];
                w_c   = w_shr[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= '0;
            r_ovf   <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            r_out   <= w_res;
            r_ovf   <= w_v;
            r_carry <= w_c;
        end
    end

    assign out             = r_out;
    assign signed_overflow = r_ovf;
    assign carry_flag      = r_carry;

`ifdef ALU_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
        end else begin
            r_zero <= (w_res == '0);
        end
    end

    assign zero_flag = r_zero;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: expected results are queued at drive time and
// popped one clock later when the registered outputs are sampled.
module tb_alu_core;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] o;
        logic         v;
        logic         c;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [2:0]   func = 3'b000;
    logic [W-1:0] out;
    logic         signed_overflow;
    logic         carry_flag;
`ifdef ALU_ZERO_FLAG_EN
    logic         zero_flag;
`endif

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    alu_core #(
        .DATA_WIDTH (W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .op_a            (op_a),
        .op_b            (op_b),
        .func            (func),
        .out             (out),
        .signed_overflow (signed_overflow),
        .carry_flag      (carry_flag)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .zero_flag       (zero_flag)
`endif
    );

    always #5 clk = ~clk;

    // Independent reference: integer range checks and bit-serial shifting.
    function automatic exp_t model(input logic r, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [2:0] f);
        exp_t         e;
        int           sa;
        int           sb;
        int           res;
        int           n;
        logic [W-1:0] t;
        e  = '0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        n  = int'(b) % W;
        t  = a;
        if (r) return e;
        case (f)
            3'd0: begin
                e.o = a + b;
                e.c = (int'(a) + int'(b)) >= (1 << W);
                res = sa + sb;
                e.v = (res > 127) || (res < -128);
            end
            3'd1: begin
                e.o = a - b;
                e.c = (a >= b);
                res = sa - sb;
                e.v = (res > 127) || (res < -128);
            end
            3'd2: e.o = a & b;
            3'd3: e.o = a | b;
            3'd4: e.o = a ^ b;
            3'd5: e.o = ~a;
            3'd6: begin
                for (int i = 0; i < n; i++) begin
                    e.c = t[W-1];
                    t   = t << 1;
                end
                e.o = t;
            end
            default: begin
                for (int i = 0; i < n; i++) begin
                    e.c = t[0];
                    t   = t >> 1;
                end
                e.o = t;
            end
        endcase
        return e;
    endfunction

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst  = 1'b1;
            op_a = 8'hFF;
            op_b = 8'h01;
            func = 3'd0;
            q.push_back('0);
            @(posedge clk);
            #1;
            e = q.pop_front();
            checks++;
            if ({out, signed_overflow, carry_flag} !== {e.o, e.v, e.c}) begin
                errors++;
                $display("FAIL reset[%0d] got out=%h V=%b C=%b exp out=%h V=%b C=%b",
                         i, out, signed_overflow, carry_flag, e.o, e.v, e.c);
            end
`ifdef ALU_ZERO_FLAG_EN
            checks++;
            if (zero_flag !== 1'b0) begin
                errors++;
                $display("FAIL reset_zero[%0d] got %b exp 0", i, zero_flag);
            end
`endif
        end
    endtask

    task automatic test_arith();
        logic [W-1:0] ta[4] = '{8'h7F, 8'hFF, 8'h80, 8'h00};
        logic [W-1:0] tb[4] = '{8'h01, 8'h01, 8'h01, 8'h01};
        logic [2:0]   tf[4] = '{3'd0, 3'd0, 3'd1, 3'd1};
        exp_t         te[4] = '{'{8'h80, 1'b1, 1'b0}, '{8'h00, 1'b0, 1'b1},
                                '{8'h7F, 1'b1, 1'b1}, '{8'hFF, 1'b0, 1'b0}};
        exp_t         e;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst  = 1'b0;
            op_a = ta[i];
            op_b = tb[i];
            func = tf[i];
            q.push_back(te[i]);
            @(posedge clk);
            #1;
            e = q.pop_front();
            checks++;
            if ({out, signed_overflow, carry_flag} !== {e.o, e.v, e.c}) begin
                errors++;
                $display("FAIL arith[%0d] got out=%h V=%b C=%b exp out=%h V=%b C=%b",
                         i, out, signed_overflow, carry_flag, e.o, e.v, e.c);
            end
        end
    endtask

    task automatic test_logic();
        logic [W-1:0] ta[4] = '{8'hF0, 8'hF0, 8'hF0, 8'hA5};
        logic [W-1:0] tb[4] = '{8'h3C, 8'h3C, 8'h3C, 8'hFF};
        logic [2:0]   tf[4] = '{3'd2, 3'd3, 3'd4, 3'd5};
        logic [W-1:0] to[4] = '{8'h30, 8'hFC, 8'hCC, 8'h5A};
        exp_t         e;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            op_a = ta[i];
            op_b = tb[i];
            func = tf[i];
            q.push_back('{to[i], 1'b0, 1'b0});
            @(posedge clk);
            #1;
            e = q.pop_front();
            checks++;
            if ({out, signed_overflow, carry_flag} !== {e.o, e.v, e.c}) begin
                errors++;
                $display("FAIL logic[%0d] got out=%h V=%b C=%b exp out=%h V=%b C=%b",
                         i, out, signed_overflow, carry_flag, e.o, e.v, e.c);
            end
        end
    endtask

    task automatic test_shift();
        logic [W-1:0] ta[5] = '{8'h81, 8'h81, 8'hC3, 8'hC3, 8'h01};
        logic [W-1:0] tb[5] = '{8'h01, 8'h09, 8'h08, 8'h10, 8'h07};
        logic [2:0]   tf[5] = '{3'd6, 3'd7, 3'd6, 3'd7, 3'd7};
        exp_t         te[5] = '{'{8'h02, 1'b0, 1'b1}, '{8'h40, 1'b0, 1'b1},
                                '{8'hC3, 1'b0, 1'b0}, '{8'hC3, 1'b0, 1'b0},
                                '{8'h00, 1'b0, 1'b0}};
        exp_t         e;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op_a = ta[i];
            op_b = tb[i];
            func = tf[i];
            q.push_back(te[i]);
            @(posedge clk);
            #1;
            e = q.pop_front();
            checks++;
            if ({out, signed_overflow, carry_flag} !== {e.o, e.v, e.c}) begin
                errors++;
                $display("FAIL shift[%0d] got out=%h V=%b C=%b exp out=%h V=%b C=%b",
                         i, out, signed_overflow, carry_flag, e.o, e.v, e.c);
            end
        end
    endtask

    // Nonzero result, then the same carry-producing ADD with rst high, then released.
    task automatic test_reset_midop();
        logic         tr[3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] ta[3] = '{8'h7F, 8'hFF, 8'hFF};
        exp_t         te[3] = '{'{8'h80, 1'b1, 1'b0}, '{8'h00, 1'b0, 1'b0},
                                '{8'h00, 1'b0, 1'b1}};
        exp_t         e;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst  = tr[i];
            op_a = ta[i];
            op_b = 8'h01;
            func = 3'd0;
            q.push_back(te[i]);
            @(posedge clk);
            #1;
            e = q.pop_front();
            checks++;
            if ({out, signed_overflow, carry_flag} !== {e.o, e.v, e.c}) begin
                errors++;
                $display("FAIL midop_reset[%0d] got out=%h V=%b C=%b exp out=%h V=%b C=%b",
                         i, out, signed_overflow, carry_flag, e.o, e.v, e.c);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 99) == 0);
            op_a = W'($urandom);
            op_b = W'($urandom);
            func = 3'($urandom);
            q.push_back(model(rst, op_a, op_b, func));
            @(posedge clk);
            #1;
            e = q.pop_front();
            checks++;
            if ({out, signed_overflow, carry_flag} !== {e.o, e.v, e.c}) begin
                errors++;
                $display("FAIL random[%0d] got out=%h V=%b C=%b exp out=%h V=%b C=%b",
                         i, out, signed_overflow, carry_flag, e.o, e.v, e.c);
            end
`ifdef ALU_ZERO_FLAG_EN
            checks++;
            if (zero_flag !== (!rst_was(e) && e.o == '0)) begin
                errors++;
                $display("FAIL random_zero[%0d] got %b exp %b", i, zero_flag,
                         (!rst_was(e) && e.o == '0));
            end
`endif
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef ALU_ZERO_FLAG_EN
    logic r_last_rst;
    always @(posedge clk) r_last_rst <= rst;

    // Reset forces zero_flag low even though the reset result is zero.
    function automatic logic rst_was(input exp_t e);
        return (e == '0) && r_last_rst;
    endfunction

    task automatic test_zero_flag();
        exp_t e;
        @(negedge clk);
        rst  = 1'b0;
        op_a = 8'h42;
        op_b = 8'h42;
        func = 3'd1;
        q.push_back('{8'h00, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks++;
        if ({out, signed_overflow, carry_flag} !== {e.o, e.v, e.c}) begin
            errors++;
            $display("FAIL zero_sub got out=%h V=%b C=%b exp out=%h V=%b C=%b",
                     out, signed_overflow, carry_flag, e.o, e.v, e.c);
        end
        checks++;
        if (zero_flag !== 1'b1) begin
            errors++;
            $display("FAIL zero_flag got %b exp 1", zero_flag);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_reset_midop();
`ifdef ALU_ZERO_FLAG_EN
        test_zero_flag();
`endif
        test_back_to_back();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
